// File: rtl/byte_max_tracker.sv
// byte_max_tracker: collects a frame of N_ITEMS unsigned candidates over a
// valid/ready input handshake, tracks the largest value and the position of
// its first occurrence, then presents that result on a valid/ready output
// handshake. Define BYTE_MAX_TRACKER_MIN_EN to also track the smallest value
// and its first position in parallel.
module byte_max_tracker #(
    parameter  int DATA_W  = 8,
    parameter  int N_ITEMS = 8,             // must be >= 2
    localparam int IDX_W   = $clog2(N_ITEMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx
`ifdef BYTE_MAX_TRACKER_MIN_EN
    ,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_min_idx
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  max_q,   max_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               first_item;
`ifdef BYTE_MAX_TRACKER_MIN_EN
    logic [DATA_W-1:0]  min_q,     min_d;
    logic [IDX_W-1:0]   min_idx_q, min_idx_d;
`else
    // Max-only build: no minimum-tracking state exists.
`endif

    // Handshake flags depend on state only, so out_ready never reaches in_ready.
    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == HOLD);
    assign out_max    = max_q;
    assign out_idx    = idx_q;
    assign first_item = (cnt_q == '0);
`ifdef BYTE_MAX_TRACKER_MIN_EN
    assign out_min     = min_q;
    assign out_min_idx = min_idx_q;
`endif

    // Next-state and datapath update: accept in COLLECT, release in HOLD.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
`ifdef BYTE_MAX_TRACKER_MIN_EN
        min_d     = min_q;
        min_idx_d = min_idx_q;
`endif
        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    // First item loads unconditionally; later ones win only
                    // when strictly greater, so ties keep the earlier index.
                    if (first_item || (in_data > max_q)) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
`ifdef BYTE_MAX_TRACKER_MIN_EN
                    if (first_item || (in_data < min_q)) begin
                        min_d     = in_data;
                        min_idx_d = cnt_q;
                    end
`endif
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
`ifdef BYTE_MAX_TRACKER_MIN_EN
            min_q     <= '0;
            min_idx_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all registers update from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
`ifdef BYTE_MAX_TRACKER_MIN_EN
            min_q     <= min_d;
            min_idx_q <= min_idx_d;
`endif
        end
    end

endmodule
